ctrl_fsm: RTL and testbench

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/ctrl_decode.sv | 43 ++++
 rtl/ctrl_fsm.sv | 146 ++++++++++++++
 tb/tb_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle controller.
// State encoding, opcode map and ALU select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_SW   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_AND = 2'd0;
    localparam logic [1:0] ALU_OR  = 2'd1;
    localparam logic [1:0] ALU_ADD = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder for ctrl_fsm.
// CTRL_FSM_SLT_EN enables the SLT ALU mapping for opcode 100.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [2:0] opcode_i,
    output logic [1:0] alu_op_o,
    output logic       alu_sub_o,
    output logic       is_mem_o,
    output logic       is_load_o,
    output logic       is_halt_o
);

    // Map opcode to ALU select and instruction class flags.
    always_comb begin
        alu_op_o  = ALU_AND;
        alu_sub_o = 1'b0;
        is_mem_o  = 1'b0;
        is_load_o = 1'b0;
        is_halt_o = 1'b0;
        unique case (opcode_i)
            OP_AND:  alu_op_o = ALU_AND;
            OP_OR:   alu_op_o = ALU_OR;
            OP_ADD:  alu_op_o = ALU_ADD;
            OP_SUB: begin
                alu_op_o  = ALU_ADD;
                alu_sub_o = 1'b1;
            end
`ifdef CTRL_FSM_SLT_EN
            OP_SLT:  alu_op_o = ALU_SLT;
`else
            OP_SLT:  alu_op_o = ALU_AND;
`endif
            OP_LW: begin
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
            end
            OP_SW:   is_mem_o  = 1'b1;
            OP_HALT: is_halt_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory timeout.
// Define CTRL_FSM_SLT_EN to execute opcode 100 as SLT instead of trapping it.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       mem_ready,
    output logic       pc_inc,
    output logic [1:0] rd_addr,
    output logic [1:0] rs_addr,
    output logic       reg_rw,
    output logic       mem_rw,
    output logic [1:0] alu_op,
    output logic       alu_sub,
    output logic       wb_sel,
    output logic       halted,
    output logic       err,
    output logic [7:0] retired
);

    localparam int WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WaitW-1:0] LastWait = WaitW'(MEM_WAIT_MAX - 1);

`ifdef CTRL_FSM_SLT_EN
    localparam bit SltEn = 1'b1;
`else
    localparam bit SltEn = 1'b0;
`endif

    state_e            state_q, state_d;
    // IR keeps instr[7:1]; bit 0 carries no meaning
    logic [6:0]        ir_q, ir_d;
    logic [7:0]        retired_q, retired_d;
    logic              err_q, err_d;
    logic [WaitW-1:0]  wait_q, wait_d;

    logic [1:0]        dec_alu_op;
    logic              dec_alu_sub;
    logic              is_mem;
    logic              is_load;
    logic              is_halt;
    logic              slt_bad;

    ctrl_decode u_decode (
        .opcode_i  (ir_q[6:4]),
        .alu_op_o  (dec_alu_op),
        .alu_sub_o (dec_alu_sub),
        .is_mem_o  (is_mem),
        .is_load_o (is_load),
        .is_halt_o (is_halt)
    );

    assign slt_bad = !SltEn && (ir_q[6:4] == OP_SLT);

    // State, IR, retire counter, error flag and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
        end
    end

    // Next-state logic; the wait counter only survives consecutive MEM stalls.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        err_d     = err_q;
        wait_d    = '0;
        unique case (state_q)
            S_FETCH: begin
                ir_d    = instr[7:1];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (slt_bad) begin
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = is_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + 8'd1;
                    end
                end else if (wait_q == LastWait) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 8'd1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Moore outputs; pc_inc is held low while reset is asserted.
    always_comb begin
        pc_inc  = (state_q == S_FETCH) && !rst;
        rd_addr = '0;
        rs_addr = '0;
        if (state_q != S_FETCH) begin
            rd_addr = ir_q[3:2];
            rs_addr = ir_q[1:0];
        end
        reg_rw  = (state_q != S_WB);
        mem_rw  = !((state_q == S_MEM) && !is_load);
        alu_op  = ALU_AND;
        alu_sub = 1'b0;
        if (((state_q == S_EXEC) || (state_q == S_WB)) && !is_mem) begin
            alu_op  = dec_alu_op;
            alu_sub = dec_alu_sub;
        end
        wb_sel  = (state_q == S_WB) && is_load;
        halted  = (state_q == S_HALT);
        err     = err_q;
        retired = retired_q;
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm against a per-instruction timing model.
// Honours CTRL_FSM_SLT_EN the same way as the design.
module tb_ctrl_fsm;

    localparam int MAXW = 7;

`ifdef CTRL_FSM_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic       mem_ready;
    logic       pc_inc;
    logic [1:0] rd_addr;
    logic [1:0] rs_addr;
    logic       reg_rw;
    logic       mem_rw;
    logic [1:0] alu_op;
    logic       alu_sub;
    logic       wb_sel;
    logic       halted;
    logic       err;
    logic [7:0] retired;

    int vectors     = 0;
    int miscompares = 0;

    // model state
    int m_ret  = 0;
    bit m_err  = 1'b0;
    bit m_halt = 1'b0;

    ctrl_fsm #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .mem_ready (mem_ready),
        .pc_inc    (pc_inc),
        .rd_addr   (rd_addr),
        .rs_addr   (rs_addr),
        .reg_rw    (reg_rw),
        .mem_rw    (mem_rw),
        .alu_op    (alu_op),
        .alu_sub   (alu_sub),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .err       (err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected {alu_op, alu_sub} for the register-register opcodes
    function automatic logic [2:0] alu_ref(input int op);
        case (op)
            0:       return 3'b00_0;
            1:       return 3'b01_0;
            2:       return 3'b10_0;
            3:       return 3'b10_1;
            default: return 3'b11_0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst.pc_inc", pc_inc, 0);
        chk("rst.reg_rw", reg_rw, 1);
        chk("rst.mem_rw", mem_rw, 1);
        chk("rst.alu_op", alu_op, 0);
        chk("rst.alu_sub", alu_sub, 0);
        chk("rst.wb_sel", wb_sel, 0);
        chk("rst.err", err, 0);
        chk("rst.halted", halted, 0);
        chk("rst.retired", retired, 0);
        m_ret  = 0;
        m_err  = 1'b0;
        m_halt = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_halt(input int n);
        for (int k = 0; k < n; k++) begin
            chk("halt.halted", halted, 1);
            chk("halt.pc_inc", pc_inc, 0);
            chk("halt.reg_rw", reg_rw, 1);
            chk("halt.mem_rw", mem_rw, 1);
            chk("halt.err", err, 32'(m_err));
            chk("halt.retired", retired, 32'(m_ret));
            instr     = 8'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    // Runs one instruction starting at a FETCH-cycle negedge; w is the
    // number of MEM cycles with mem_ready low before it rises.
    task automatic run_instr(input logic [7:0] ins, input int w);
        int         op;
        bit         alu;
        bit         load;
        bit         ok;
        int         i;
        logic [2:0] ar;
        op   = int'(ins[7:5]);
        alu  = (op <= 4);
        load = (op == 5);
        ar   = alu_ref(op);
        chk("fetch.pc_inc", pc_inc, 1);
        chk("fetch.retired", retired, 32'(m_ret));
        chk("fetch.err", err, 32'(m_err));
        chk("fetch.halted", halted, 0);
        chk("fetch.reg_rw", reg_rw, 1);
        chk("fetch.mem_rw", mem_rw, 1);
        instr = ins;
        @(negedge clk);
        chk("dec.pc_inc", pc_inc, 0);
        chk("dec.reg_rw", reg_rw, 1);
        chk("dec.mem_rw", mem_rw, 1);
        chk("dec.rd", rd_addr, 32'(ins[4:3]));
        chk("dec.rs", rs_addr, 32'(ins[2:1]));
        instr = 8'($urandom);
        @(negedge clk);
        if (op == 7) begin
            m_halt = 1'b1;
            return;
        end
        if (op == 4 && !SLT_EN) begin
            m_err = 1'b1;
            return;
        end
        chk("exec.pc_inc", pc_inc, 0);
        chk("exec.reg_rw", reg_rw, 1);
        chk("exec.mem_rw", mem_rw, 1);
        chk("exec.rd", rd_addr, 32'(ins[4:3]));
        if (alu) begin
            chk("exec.alu_op", alu_op, 32'(ar[2:1]));
            chk("exec.alu_sub", alu_sub, 32'(ar[0]));
        end
        @(negedge clk);
        if (!alu) begin
            i  = 0;
            ok = 1'b0;
            while (!ok && i < MAXW) begin
                chk("mem.pc_inc", pc_inc, 0);
                chk("mem.mem_rw", mem_rw, 32'(load));
                chk("mem.reg_rw", reg_rw, 1);
                chk("mem.halted", halted, 0);
                chk("mem.rs", rs_addr, 32'(ins[2:1]));
                mem_ready = (i >= w);
                @(negedge clk);
                ok = (i >= w);
                i++;
            end
            mem_ready = 1'b0;
            if (!ok) begin
                m_err  = 1'b1;
                m_halt = 1'b1;
                return;
            end
            if (!load) begin
                m_ret = (m_ret + 1) & 255;
                return;
            end
        end
        chk("wb.pc_inc", pc_inc, 0);
        chk("wb.reg_rw", reg_rw, 0);
        chk("wb.mem_rw", mem_rw, 1);
        chk("wb.wb_sel", wb_sel, 32'(load));
        chk("wb.rd", rd_addr, 32'(ins[4:3]));
        if (alu) begin
            chk("wb.alu_op", alu_op, 32'(ar[2:1]));
            chk("wb.alu_sub", alu_sub, 32'(ar[0]));
        end
        @(negedge clk);
        m_ret = (m_ret + 1) & 255;
    endtask

    initial begin
        logic [2:0] op;
        int         w;
        rst       = 1'b0;
        instr     = '0;
        mem_ready = 1'b0;
        #2;
        do_reset();

        // ADD r1,r2 then LW with two stall cycles
        run_instr(8'b010_01_10_0, 0);
        chk("add.retired", retired, 1);
        run_instr(8'b101_10_01_0, 2);
        run_instr(8'b011_11_00_0, 0);
        run_instr(8'b110_00_11_0, 1);

        // mem_ready on the last allowed MEM cycle is still a success
        run_instr(8'b110_01_01_0, MAXW - 1);
        run_instr(8'b101_01_01_0, MAXW - 1);
        chk("edge.err", err, 0);

        // reset pulse in the middle of EXEC
        chk("mid.pc_inc", pc_inc, 1);
        instr = 8'b000_11_01_0;
        @(negedge clk);
        @(negedge clk);
        chk("mid.exec_rd", rd_addr, 3);
        do_reset();

        // SW that never completes times out into HALT
        run_instr(8'b110_01_10_0, 100);
        check_halt(3);
        do_reset();

        // HALT instruction is absorbing
        run_instr(8'hE0, 0);
        check_halt(20);
        do_reset();

        // retire counter wraps after 256 instructions
        for (int k = 0; k < 256; k++) run_instr(8'b010_01_10_0, 0);
        chk("wrap.retired", retired, 0);

        // opcode 100: SLT or trapped NOP
        run_instr(8'b100_01_10_0, 0);
        chk("slt.err", err, SLT_EN ? 0 : 1);
        chk("slt.retired", retired, SLT_EN ? 1 : 0);
        do_reset();

        // random instruction stream
        for (int k = 0; k < 150; k++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd7 && $urandom_range(0, 3) != 0)
                op = 3'd2;
            if ($urandom_range(0, 9) == 0)
                w = $urandom_range(0, 10);
            else
                w = $urandom_range(0, 3);
            run_instr({op, 5'($urandom)}, w);
            if (m_halt) begin
                check_halt(3);
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
